// File: rtl/sort4_pkg.sv
// Shared types and constants for the sort4 controller and its comparator.
`timescale 1ns/1ps
package sort4_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Pointer width for a burst of 'depth' words; never narrower than 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mag_cmp4.sv
// Combinational 4-bit unsigned magnitude comparator shared by every SORT step.
`timescale 1ns/1ps
module mag_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// Burst sorter: load DEPTH words, bubble-sort in place with one shared
// comparator (early exit on a swap-free pass), then drain in ascending order.
`timescale 1ns/1ps
module sort4_ctrl
    import sort4_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int            PW       = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [PW-1:0] CMP_LAST = PW'(DEPTH - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_idx;
    logic [PW-1:0]    r_pass;
    logic             r_swapped;

    logic [PW-1:0]    w_idx1;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic             w_swap;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_done;
    logic             w_pass_end;
    logic             w_sort_done;
    logic             w_drain_done;

    assign w_idx1 = r_idx + 1'b1;
    assign w_a    = r_buf[r_idx];
    assign w_b    = r_buf[w_idx1];

    mag_cmp4 u_cmp (
        .a  (w_a),
        .b  (w_b),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    // Swap only on strict greater-than; equal pairs stay put so the sort is stable.
    assign w_swap = (r_state == SORT) && w_gt && !(w_eq || w_lt);

    assign w_in_fire    = (r_state == LOAD)  && in_valid;
    assign w_out_fire   = (r_state == DRAIN) && out_ready;
    assign w_load_done  = w_in_fire  && (r_wr_ptr == LAST);
    assign w_drain_done = w_out_fire && (r_rd_ptr == LAST);
    assign w_pass_end   = (r_state == SORT) && (r_idx == CMP_LAST);
    // The current comparison's swap counts toward the pass it ends.
    assign w_sort_done  = w_pass_end &&
                          (!(r_swapped || w_swap) || (r_pass == CMP_LAST));

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign busy      = (r_state != LOAD);
    assign out_data  = (r_state == DRAIN) ? r_buf[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_load_done)  w_state_nxt = SORT;
            SORT:    if (w_sort_done)  w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_done) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_idx     <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_wr_ptr] <= in_data;
                        if (w_load_done) begin
                            r_wr_ptr  <= '0;
                            r_idx     <= '0;
                            r_pass    <= '0;
                            r_swapped <= 1'b0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (w_swap) begin
                        r_buf[r_idx]  <= w_b;
                        r_buf[w_idx1] <= w_a;
                    end
                    if (w_pass_end) begin
                        r_idx     <= '0;
                        r_swapped <= 1'b0;
                        if (!w_sort_done) r_pass <= r_pass + 1'b1;
                    end else begin
                        r_idx     <= w_idx1;
                        r_swapped <= r_swapped || w_swap;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_drain_done) r_rd_ptr <= '0;
                        else              r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
